// File: rtl/mac_tx_sequencer_pkg.sv
// Shared defaults, FSM encoding and whitening LFSR constants for the MAC TX sequencer.
// The LFSR helpers are only used when MAC_TX_WHITEN_EN is defined.
package mac_tx_sequencer_pkg;

    localparam int unsigned DIV_DEF      = 50;
    localparam int unsigned WORD_W_DEF   = 8;
    localparam int unsigned CHIP_DIV_DEF = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHead = 2'd1,
        StData = 2'd2,
        StGap  = 2'd3
    } tx_state_e;

    // x^7 + x^4 + 1, Fibonacci form; output is the MSB
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam int unsigned LFSR_TAP_A = 6;
    localparam int unsigned LFSR_TAP_B = 3;

    function automatic logic [6:0] lfsr_next(input logic [6:0] s);
        return {s[5:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/mac_tx_sequencer_bit_strobe_gen.sv
// Free-running DIV divider; bit_stb pulses for one clock when the count reaches DIV-1.
// Also usable as the MAC's clock-enable source.
module bit_strobe_gen #(
    parameter int unsigned DIV = 50
) (
    input  logic clock,
    input  logic reset,
    output logic bit_stb
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_stb = (cnt_q == CntMax);
        cnt_d   = bit_stb ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_tx_sequencer.sv
// MAC TX sequencer: header bit hold, payload prefetch and MSB-first chip serialisation.
// Define MAC_TX_WHITEN_EN to XOR data chips with an x^7+x^4+1 LFSR.
module mac_tx_sequencer
    import mac_tx_sequencer_pkg::*;
#(
    parameter int unsigned DIV      = DIV_DEF,
    parameter int unsigned WORD_W   = WORD_W_DEF,
    parameter int unsigned CHIP_DIV = CHIP_DIV_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sending,
    input  logic              head,
    input  logic              datacmd,
    input  logic              working,
    output logic              bit_stb,
    output logic              pl_req,
    input  logic              pl_ack,
    input  logic [WORD_W-1:0] pl_data,
    input  logic              pl_empty,
    output logic              mod_en,
    output logic              mod_bit,
    output logic              underrun,
    output logic              busy
);

    localparam int unsigned ChipW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int unsigned IdxW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [ChipW-1:0] ChipMax = ChipW'(CHIP_DIV - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(WORD_W - 1);

    tx_state_e         state_q, state_d;
    logic              head_q, head_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic [ChipW-1:0]  chip_q, chip_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              pl_req_q, pl_req_d;
    logic              underrun_q, underrun_d;
    logic              consume;
    logic              whiten_bit;
`ifdef MAC_TX_WHITEN_EN
    logic [6:0]        lfsr_q, lfsr_d;
`endif

    bit_strobe_gen #(
        .DIV(DIV)
    ) u_bit_strobe_gen (
        .clock  (clock),
        .reset  (reset),
        .bit_stb(bit_stb)
    );

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        chip_d       = chip_q;
        idx_d        = idx_q;
        pl_req_d     = pl_req_q;
        underrun_d   = underrun_q;
        consume      = 1'b0;
`ifdef MAC_TX_WHITEN_EN
        lfsr_d       = lfsr_q;
`endif

        if (state_q == StData) begin
            if (chip_q == ChipMax) begin
                chip_d  = '0;
                shift_d = shift_q << 1;
`ifdef MAC_TX_WHITEN_EN
                lfsr_d  = lfsr_next(lfsr_q);
`endif
                if (idx_q == IdxMax) begin
                    state_d = StGap;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end else begin
                chip_d = chip_q + ChipW'(1);
            end
        end

        // The strobe decision always wins over whatever the current state was doing
        if (bit_stb) begin
            chip_d = '0;
            idx_d  = '0;
            if (!working || !sending) begin
                state_d = StIdle;
            end else if (!datacmd) begin
                state_d = StHead;
                head_d  = head;
`ifdef MAC_TX_WHITEN_EN
                if (state_q == StIdle) begin
                    lfsr_d = LFSR_SEED;
                end
`endif
            end else if (word_valid_q) begin
                state_d = StData;
                shift_d = word_q;
                consume = 1'b1;
            end else begin
                state_d    = StGap;
                underrun_d = 1'b1;
            end
        end

        // Prefetch: a consumed word may be refetched in the same cycle
        if (consume) begin
            word_valid_d = 1'b0;
        end
        if (pl_req_q) begin
            if (pl_ack) begin
                word_d       = pl_data;
                word_valid_d = 1'b1;
                pl_req_d     = 1'b0;
            end
        end else begin
            pl_req_d = (!word_valid_q || consume) && !pl_empty;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            head_q       <= 1'b0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            chip_q       <= '0;
            idx_q        <= '0;
            pl_req_q     <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef MAC_TX_WHITEN_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            chip_q       <= chip_d;
            idx_q        <= idx_d;
            pl_req_q     <= pl_req_d;
            underrun_q   <= underrun_d;
`ifdef MAC_TX_WHITEN_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

`ifdef MAC_TX_WHITEN_EN
    assign whiten_bit = lfsr_q[6];
`else
    assign whiten_bit = 1'b0;
`endif

    always_comb begin
        pl_req   = pl_req_q;
        underrun = underrun_q;
        busy     = (state_q != StIdle);
        mod_en   = 1'b0;
        mod_bit  = 1'b0;
        unique case (state_q)
            StHead: begin
                mod_en  = 1'b1;
                mod_bit = head_q;
            end
            StData: begin
                mod_en  = 1'b1;
                mod_bit = shift_q[WORD_W-1] ^ whiten_bit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mac_tx_sequencer.sv
// Directed self-checking bench for mac_tx_sequencer (DIV=50, WORD_W=8, CHIP_DIV=6).
// Expected chips follow the LFSR model when MAC_TX_WHITEN_EN is defined.
module tb_mac_tx_sequencer;

    logic       clock;
    logic       reset;
    logic       sending;
    logic       head;
    logic       datacmd;
    logic       working;
    logic       bit_stb;
    logic       pl_req;
    logic       pl_ack;
    logic [7:0] pl_data;
    logic       pl_empty;
    logic       mod_en;
    logic       mod_bit;
    logic       underrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    mac_tx_sequencer #(
        .DIV     (50),
        .WORD_W  (8),
        .CHIP_DIV(6)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sending (sending),
        .head    (head),
        .datacmd (datacmd),
        .working (working),
        .bit_stb (bit_stb),
        .pl_req  (pl_req),
        .pl_ack  (pl_ack),
        .pl_data (pl_data),
        .pl_empty(pl_empty),
        .mod_en  (mod_en),
        .mod_bit (mod_bit),
        .underrun(underrun),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stb"}, {31'd0, bit_stb}, 32'd0);
        chk({tag, "_req"}, {31'd0, pl_req}, 32'd0);
        chk({tag, "_en"}, {31'd0, mod_en}, 32'd0);
        chk({tag, "_bit"}, {31'd0, mod_bit}, 32'd0);
        chk({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Call in the cycle right after the last reset edge; strobe must be the 50th cycle
    task automatic first_stb(input string tag);
        int n = 1;
        while (!bit_stb && n < 100) begin
            step();
            n++;
        end
        chk(tag, n, 50);
    endtask

    task automatic wait_stb();
        int k = 0;
        while (!bit_stb && k < 60) begin
            step();
            k++;
        end
        chk("wait_stb", {31'd0, bit_stb}, 32'd1);
    endtask

    initial begin
        logic [7:0] word;
        logic [6:0] lfsr_m;
        logic       exp_bit;
        int         cnt_hi;

        reset    = 1'b0;
        sending  = 1'b0;
        head     = 1'b0;
        datacmd  = 1'b0;
        working  = 1'b1;
        pl_ack   = 1'b0;
        pl_data  = 8'h00;
        pl_empty = 1'b1;
        lfsr_m   = 7'h7F;

        // Power-on reset
        repeat (3) step();
        chk_all_zero("por");
        reset = 1'b1;
        first_stb("por_first_stb");

        // Header bit held for a full strobe period
        sending = 1'b1;
        datacmd = 1'b0;
        head    = 1'b1;
        step();
        chk("head_en0", {31'd0, mod_en}, 32'd1);
        chk("head_busy", {31'd0, busy}, 32'd1);
        sending = 1'b0;
        cnt_hi  = 0;
        for (int i = 0; i < 60; i++) begin
            if (mod_en && mod_bit) cnt_hi++;
            if (bit_stb) break;
            step();
        end
        chk("head_len", cnt_hi, 50);
        step();
        chk("head_end_en", {31'd0, mod_en}, 32'd0);
        chk("head_end_busy", {31'd0, busy}, 32'd0);

        // Prefetch with ack delayed 10 clocks
        pl_empty = 1'b0;
        step();
        chk("req_rise", {31'd0, pl_req}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("req_hold", {31'd0, pl_req}, 32'd1);
        end
        pl_ack   = 1'b1;
        pl_data  = 8'hA5;
        pl_empty = 1'b1;
        step();
        pl_ack = 1'b0;
        chk("req_drop", {31'd0, pl_req}, 32'd0);
        // Stray ack without a request must not replace the word
        pl_ack  = 1'b1;
        pl_data = 8'hFF;
        step();
        pl_ack = 1'b0;
        chk("stray_ack_req", {31'd0, pl_req}, 32'd0);

        // Header then data token carrying 8'hA5
        wait_stb();
        sending = 1'b1;
        datacmd = 1'b0;
        head    = 1'b0;
        step();
        chk("hdr0_en", {31'd0, mod_en}, 32'd1);
        chk("hdr0_bit", {31'd0, mod_bit}, 32'd0);
        datacmd = 1'b1;
        wait_stb();
        step();
        word = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            exp_bit = word[7-b];
`ifdef MAC_TX_WHITEN_EN
            exp_bit = exp_bit ^ lfsr_m[6];
            lfsr_m  = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[3]};
`endif
            for (int c = 0; c < 6; c++) begin
                chk("data_en", {31'd0, mod_en}, 32'd1);
                chk("data_bit", {31'd0, mod_bit}, {31'd0, exp_bit});
                step();
            end
        end
        chk("gap_en0", {31'd0, mod_en}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        step();
        chk("gap_stb", {31'd0, bit_stb}, 32'd1);
        chk("gap_en1", {31'd0, mod_en}, 32'd0);

        // Data token with empty buffer -> underrun
        step();
        chk("ur_flag", {31'd0, underrun}, 32'd1);
        chk("ur_en", {31'd0, mod_en}, 32'd0);
        chk("ur_busy", {31'd0, busy}, 32'd1);
        chk("ur_req", {31'd0, pl_req}, 32'd0);
        sending = 1'b0;
        wait_stb();
        step();
        chk("ur_idle", {31'd0, busy}, 32'd0);
        chk("ur_sticky", {31'd0, underrun}, 32'd1);

        // Reset held 3 clocks in the middle of a data token
        pl_empty = 1'b0;
        step();
        chk("re_req", {31'd0, pl_req}, 32'd1);
        pl_ack  = 1'b1;
        pl_data = 8'h3C;
        step();
        pl_ack   = 1'b0;
        pl_empty = 1'b1;
        sending  = 1'b1;
        datacmd  = 1'b1;
        wait_stb();
        step();
        repeat (5) step();
        chk("mid_data_en", {31'd0, mod_en}, 32'd1);
        reset = 1'b0;
        step();
        chk_all_zero("rst");
        step();
        step();
        reset   = 1'b1;
        sending = 1'b0;
        datacmd = 1'b0;
        first_stb("rst_first_stb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
